yrv_mem_arbiter: RTL
====================

Name: yrv_mem_arbiter

Overview:
- Two-master, one-slave arbiter for the YRV MCU memory port.
- Master 0 is the CPU data/instruction side. Master 1 is the auxiliary UART boot loader or debug loader.
- The slave is the shared MCU memory.
- Supports round-robin or fixed priority, locked (read-modify-write) sequences, and a lock-release timeout so a stalled locked owner cannot starve the other master.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-lane width is DATA_W/8.
- FAIR, 1, 1 = round-robin on contention; 0 = fixed priority, m0 always wins.
- LOCK_TMO, 16, idle cycles a locked owner may hold the grant without requesting (range ≥2).

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 access request.
- m0_write  in  1  master 0 write (1) / read (0).
- m0_lock  in  1  master 0 keeps grant after this access.
- m0_ble  in  DATA_W/8  master 0 byte lane enables.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_ready  out  1  master 0 access complete.
- m0_rdata  out  DATA_W  master 0 read data.
- m1_req, m1_write, m1_lock, m1_ble, m1_addr, m1_wdata, m1_ready, m1_rdata: same as master 0, for master 1.
- s_req  out  1  slave access strobe.
- s_write  out  1  slave write.
- s_ble  out  DATA_W/8  slave byte lane enables.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_ready  in  1  slave completes access.
- s_rdata  in  DATA_W  slave read data.
- gnt_id  out  1  current or last owner.
- busy  out  1  state is not ARB.

Behaviour:
- Master rule: hold req and all fields stable from assertion until the cycle mN_ready=1. req may stay high after ready; that presents the next access.
- Access completes in a cycle where s_req & s_ready.
- States: ARB, XFER, HOLD. Registers: state, owner, last, tmo_cnt.
- ARB:
  - s_req=0.
  - No req: stay in ARB.
  - One req: owner=requester, go to XFER.
  - Both req, FAIR=1: owner = !last. FAIR=0: owner=0.
  - On entering XFER: last<=owner.
- XFER:
  - s_req=1, independent of mN_req.
  - s_write/s_ble/s_addr/s_wdata are a combinational mux of the owner's inputs.
  - Owner's ready = s_ready; owner's rdata = s_rdata.
  - Non-owner ready=0, rdata=0.
  - On completion: owner lock=1 → HOLD with tmo_cnt<=0; lock=0 → ARB.
  - s_ready=0: stay in XFER; any number of wait states allowed.
- HOLD:
  - s_req=0. Non-owner req is ignored.
  - Owner req=1 → XFER, same owner.
  - Otherwise tmo_cnt++. When tmo_cnt==LOCK_TMO-1 → ARB; the lock is broken.
- Latency: request seen in ARB → s_req next cycle. Minimum access is 2 cycles (ARB + XFER with s_ready=1). Locked back-to-back accesses also cost 2 cycles each (HOLD + XFER).
- gnt_id = owner while busy; holds the last owner in ARB.
- Outside XFER: all s_* outputs are 0 and mN_ready=0.
- s_ready outside XFER is ignored.
- Reset, including mid-XFER or mid-HOLD:
  - state=ARB, owner=0, last=1 (so the first FAIR tie goes to m0), tmo_cnt=0.
  - All outputs 0 the cycle after reset is sampled high.
  - An aborted access is not reported complete.
- Simultaneous events:
  - Non-owner request arriving during XFER completion with lock=0: served in the next ARB cycle.
  - Owner request in the same cycle the timeout expires: timeout wins, go to ARB; the owner rearbitrates.

Test Plan:
- Reset, m0 read addr 0x100, s_ready in first XFER cycle, s_rdata=0xDEADBEEF → s_req 1 cycle after req; m0_ready=1 and m0_rdata=0xDEADBEEF in cycle 2; m1_rdata=0.
- FAIR=1, m0_req and m1_req held high for 6 accesses → grant order 0,1,0,1,0,1; gnt_id matches; s_addr follows the owner.
- FAIR=0, same stimulus → all 6 grants to m0; m1 is served only after m0_req drops.
- m1 write with m1_lock=1, then m1 read with lock=0 4 cycles later, m0_req high throughout → m0 not granted until the m1 read completes; s_req low during HOLD.
- LOCK_TMO=4, m0 locked access, then m0 idle, m1_req high → after 4 HOLD cycles go to ARB, m1 granted next; verify 3- and 4-cycle boundaries.
- XFER with s_ready low for 5 cycles, reset asserted in cycle 3 → outputs 0 next cycle, no mN_ready pulse; after release, m0 wins a tie.

Source files
------------

// File: rtl/yrv_mem_arbiter.sv
// yrv_mem_arbiter
//   Two-master / one-slave arbiter for the YRV MCU memory port.
//   Master 0 is the CPU side. Master 1 is the boot/debug loader.
//   On contention it uses round-robin (FAIR=1) or fixed priority with m0 winning (FAIR=0).
//   A master that sets mN_lock keeps the grant after its access. The grant then sits in HOLD.
//   If the owner stays idle for LOCK_TMO cycles, the lock is dropped.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   mN_req/write/lock       master N request, direction, keep-grant flag
//   mN_ble/addr/wdata       master N byte lanes, address, write data
//   mN_ready/rdata          master N completion strobe and read data
//   s_req/write/ble/addr/wdata  slave access (driven only in XFER)
//   s_ready/rdata           slave completion and read data
//   gnt_id                  current owner (last owner while idle)
//   busy                    arbiter not in ARB
//
// State  | meaning
// -------+-------------------------------------------------
// ARB    | idle; pick an owner from the pending requests
// XFER   | slave access in progress for the owner
// HOLD   | locked owner keeps the grant; timeout running

module yrv_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int FAIR     = 1,
  parameter int LOCK_TMO = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_write,
  input  logic                m0_lock,
  input  logic [DATA_W/8-1:0] m0_ble,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_write,
  input  logic                m1_lock,
  input  logic [DATA_W/8-1:0] m1_ble,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_req,
  output logic                s_write,
  output logic [DATA_W/8-1:0] s_ble,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                gnt_id,
  output logic                busy
);

  localparam int TMO_W = (LOCK_TMO > 2) ? $clog2(LOCK_TMO) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TMO - 1);

  typedef enum logic [1:0] {ARB, XFER, HOLD} state_t;

  state_t           state;
  logic             owner;
  logic             last;
  logic [TMO_W-1:0] tmo_cnt;

  logic own_req;
  logic own_lock;
  logic pick;
  logic in_xfer;

  assign own_req  = owner ? m1_req  : m0_req;
  assign own_lock = owner ? m1_lock : m0_lock;
  assign in_xfer  = (state == XFER);

  // On a tie, round-robin gives the grant to the master that did not go last.
  // Reset sets last=1, so the first tie goes to m0.
  always_comb begin
    pick = 1'b0;
    if (m0_req && m1_req) begin
      pick = (FAIR != 0) ? ~last : 1'b0;
    end else if (m1_req) begin
      pick = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB;
      owner   <= 1'b0;
      last    <= 1'b1;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          if (m0_req || m1_req) begin
            owner <= pick;
            last  <= pick;
            state <= XFER;
          end
        end
        XFER: begin
          if (s_ready) begin
            if (own_lock) begin
              state   <= HOLD;
              tmo_cnt <= '0;
            end else begin
              state <= ARB;
            end
          end
        end
        HOLD: begin
          // Expiry is checked before the owner request, so a request that
          // lands on the last idle cycle loses the lock and rearbitrates.
          if (tmo_cnt == TMO_LAST) begin
            state   <= ARB;
            tmo_cnt <= '0;
          end else if (own_req) begin
            state <= XFER;
            last  <= owner;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  always_comb begin
    s_req    = 1'b0;
    s_write  = 1'b0;
    s_ble    = '0;
    s_addr   = '0;
    s_wdata  = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (in_xfer) begin
      s_req   = 1'b1;
      s_write = owner ? m1_write : m0_write;
      s_ble   = owner ? m1_ble   : m0_ble;
      s_addr  = owner ? m1_addr  : m0_addr;
      s_wdata = owner ? m1_wdata : m0_wdata;
      if (owner) begin
        m1_ready = s_ready;
        m1_rdata = s_rdata;
      end else begin
        m0_ready = s_ready;
        m0_rdata = s_rdata;
      end
    end
  end

  assign gnt_id = owner;
  assign busy   = (state != ARB);

endmodule
